// File: rtl/panel_clock_ctrl.sv
// panel_clock_ctrl: CPU clock-enable generator for run fast/slow and single-step.
// Define BURST_STEP_EN to auto-repeat steps while the cycle switch is held.
module panel_clock_ctrl #(
  parameter int unsigned FAST_DIV    = 366,
  parameter int unsigned SLOW_DIV    = 12000000,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned HOLD_CYCLES = 6000000,
  parameter int unsigned REPEAT_DIV  = 1200000
) (
  input  logic        hwclk,
  input  logic        reset,
  input  logic        run_sw,
  input  logic        step_mode_sw,
  input  logic        fast_sw,
  input  logic        cycle_sw,
  output logic        cpu_ce,
  output logic        running,
  output logic [15:0] ce_count
);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_STEP_IDLE,
    ST_STEP_HELD
  } state_t;

  state_t state, state_d;

  logic [1:0] run_q, step_q, fast_q, cyc_q;
  logic run_s, step_s, fast_s, cyc_s;
  logic fast_prev, cyc_prev;
  logic [CNT_W-1:0] presc, presc_d, div_last;
  logic ce_d;
  logic rep_fire;

  assign run_s  = run_q[1];
  assign step_s = step_q[1];
  assign fast_s = fast_q[1];
  assign cyc_s  = cyc_q[1];

  assign div_last = fast_s ? CNT_W'(FAST_DIV - 1)
                           : CNT_W'(SLOW_DIV - 1);

  always_ff @(posedge hwclk) begin
    if (reset) begin
      run_q  <= '0;
      step_q <= '0;
      fast_q <= '0;
      cyc_q  <= '0;
    end else begin
      run_q  <= {run_q[0], run_sw};
      step_q <= {step_q[0], step_mode_sw};
      fast_q <= {fast_q[0], fast_sw};
      cyc_q  <= {cyc_q[0], cycle_sw};
    end
  end

`ifdef BURST_STEP_EN
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned RW = $clog2(REPEAT_DIV + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_DIV - 1);

  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  logic          hold_done;
  logic          pressed;

  // hold_cnt counts pressed cycles in step mode, including the edge cycle
  assign pressed   = cyc_s &&
                     (state == ST_STEP_IDLE || state == ST_STEP_HELD);
  assign hold_done = (hold_cnt == HOLD_LAST);
  assign rep_fire  = hold_done && (rep_cnt == '0);

  always_ff @(posedge hwclk) begin
    if (reset || !pressed) begin
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else if (!hold_done) begin
      hold_cnt <= hold_cnt + 1'b1;
    end else begin
      rep_cnt <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    state_d = state;
    presc_d = presc;
    ce_d    = 1'b0;
    unique case (state)
      ST_STOP: begin
        if (!step_s) begin
          state_d = ST_STEP_IDLE;
        end else if (run_s) begin
          state_d = ST_RUN;
          presc_d = '0;
        end
      end
      ST_RUN: begin
        if (!step_s) begin
          state_d = ST_STEP_IDLE;
        end else if (!run_s) begin
          state_d = ST_STOP;
        end else if (fast_s != fast_prev) begin
          presc_d = '0;
        end else if (presc == div_last) begin
          ce_d    = 1'b1;
          presc_d = '0;
        end else begin
          presc_d = presc + 1'b1;
        end
      end
      ST_STEP_IDLE: begin
        if (step_s) begin
          state_d = run_s ? ST_RUN : ST_STOP;
          presc_d = '0;
        end else if (cyc_s && !cyc_prev) begin
          ce_d    = 1'b1;
          state_d = ST_STEP_HELD;
        end
      end
      ST_STEP_HELD: begin
        if (step_s) begin
          state_d = run_s ? ST_RUN : ST_STOP;
          presc_d = '0;
        end else if (!cyc_s) begin
          state_d = ST_STEP_IDLE;
        end else begin
          ce_d = rep_fire;
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      state     <= ST_STOP;
      presc     <= '0;
      cpu_ce    <= 1'b0;
      running   <= 1'b0;
      ce_count  <= '0;
      fast_prev <= 1'b0;
      cyc_prev  <= 1'b0;
    end else begin
      state     <= state_d;
      presc     <= presc_d;
      cpu_ce    <= ce_d;
      running   <= (state_d == ST_RUN);
      fast_prev <= fast_s;
      cyc_prev  <= cyc_s;
      if (ce_d) ce_count <= ce_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_panel_clock_ctrl.sv
// tb_panel_clock_ctrl: directed bench for panel_clock_ctrl.
// Second instance with FAST_DIV=1 drives ce_count through its 16-bit wrap.
module tb_panel_clock_ctrl;

  logic        hwclk = 1'b0;
  logic        reset, run_sw, step_mode_sw, fast_sw, cycle_sw;
  logic        cpu_ce, running;
  logic [15:0] ce_count;

  logic        w_reset, w_run, w_step, w_fast, w_cyc;
  logic        w_ce, w_running;
  logic [15:0] w_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses[$];
  int t0;

  always #5 hwclk = ~hwclk;

  panel_clock_ctrl #(
    .FAST_DIV(4), .SLOW_DIV(10), .CNT_W(4),
    .HOLD_CYCLES(20), .REPEAT_DIV(5)
  ) dut (
    .hwclk(hwclk), .reset(reset), .run_sw(run_sw),
    .step_mode_sw(step_mode_sw), .fast_sw(fast_sw),
    .cycle_sw(cycle_sw), .cpu_ce(cpu_ce),
    .running(running), .ce_count(ce_count)
  );

  panel_clock_ctrl #(
    .FAST_DIV(1), .SLOW_DIV(2), .CNT_W(2),
    .HOLD_CYCLES(20), .REPEAT_DIV(5)
  ) wrap (
    .hwclk(hwclk), .reset(w_reset), .run_sw(w_run),
    .step_mode_sw(w_step), .fast_sw(w_fast),
    .cycle_sw(w_cyc), .cpu_ce(w_ce),
    .running(w_running), .ce_count(w_count)
  );

  always @(posedge hwclk) begin
    #1;
    cyc++;
    if (cpu_ce) pulses.push_back(cyc);
  end

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic check_train(input string tag, input int base,
                             input int skip, input int first,
                             input int period, input int n);
    for (int i = 0; i < n; i++) begin
      if (skip + i < pulses.size())
        check(tag, 32'(pulses[skip+i] - base), 32'(first + period*i));
      else
        check(tag, 32'hdead, 32'(first + period*i));
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  initial begin
    reset = 1'b1; run_sw = 1'b0; step_mode_sw = 1'b0;
    fast_sw = 1'b0; cycle_sw = 1'b0;
    w_reset = 1'b1; w_run = 1'b0; w_step = 1'b0;
    w_fast = 1'b0; w_cyc = 1'b0;

    ticks(3);
    check("rst_ce", 32'(cpu_ce), 0);
    check("rst_running", 32'(running), 0);
    check("rst_count", 32'(ce_count), 0);
    check("rst_state", 32'(dut.state), 0);

    // fast run: entry at edge 3, pulses every 4 from edge 7
    reset = 1'b0; step_mode_sw = 1'b1; run_sw = 1'b1; fast_sw = 1'b1;
    t0 = cyc; pulses.delete();
    ticks(40);
    check("run_running", 32'(running), 1);
    check("fast_n", 32'(pulses.size()), 9);
    check_train("fast_t", t0, 0, 7, 4, 9);
    check("fast_count", 32'(ce_count), 9);

    // rate change suppresses the edge-43 pulse, restarts the prescaler
    t0 = cyc; pulses.delete(); fast_sw = 1'b0;
    ticks(40);
    check("slow_n", 32'(pulses.size()), 3);
    check_train("slow_t", t0, 0, 13, 10, 3);
    check("slow_count", 32'(ce_count), 12);

    // entering step mode eats the pulse due on the exit cycle
    t0 = cyc; pulses.delete(); step_mode_sw = 1'b0;
    ticks(5);
    check("step_n", 32'(pulses.size()), 0);
    check("step_running", 32'(running), 0);
    check("step_state", 32'(dut.state), 2);

    for (int p = 0; p < 3; p++) begin
      t0 = cyc; pulses.delete(); cycle_sw = 1'b1;
      ticks(30);
      cycle_sw = 1'b0;
      ticks(10);
`ifdef BURST_STEP_EN
      check("press_n", 32'(pulses.size()), 4);
      check_train("press_t", t0, 0, 3, 0, 1);
      check_train("press_rep", t0, 1, 22, 5, 3);
`else
      check("press_n", 32'(pulses.size()), 1);
      check_train("press_t", t0, 0, 3, 0, 1);
`endif
    end

    t0 = cyc; pulses.delete(); cycle_sw = 1'b1;
    ticks(40);
    cycle_sw = 1'b0;
    ticks(10);
`ifdef BURST_STEP_EN
    check("hold_n", 32'(pulses.size()), 6);
    check_train("hold_t", t0, 0, 3, 0, 1);
    check_train("hold_rep", t0, 1, 22, 5, 5);
    check("step_count", 32'(ce_count), 30);
`else
    check("hold_n", 32'(pulses.size()), 1);
    check_train("hold_t", t0, 0, 3, 0, 1);
    check("step_count", 32'(ce_count), 16);
`endif

    // leave step mode with run off -> STOP
    pulses.delete(); step_mode_sw = 1'b1; run_sw = 1'b0;
    ticks(5);
    check("exit_state", 32'(dut.state), 0);
    check("exit_n", 32'(pulses.size()), 0);
    check("exit_running", 32'(running), 0);

    // wrap instance: pulse every edge from edge 4, count = k-3
    w_reset = 1'b0; w_step = 1'b1; w_run = 1'b1; w_fast = 1'b1;
    ticks(65537);
    check("wrap_fffe", 32'(w_count), 32'hfffe);
    ticks(1);
    check("wrap_ffff", 32'(w_count), 32'hffff);
    ticks(1);
    check("wrap_0000", 32'(w_count), 0);
    check("wrap_ce_hi", 32'(w_ce), 1);
    w_reset = 1'b1;
    ticks(1);
    check("rst_mid_ce", 32'(w_ce), 0);
    check("rst_mid_count", 32'(w_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
